serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor: the sequential successor to the single-bit full adder. Captures two WIDTH-bit operands on a start strobe and processes DIGIT bits per clock through a registered carry. Reports sum, carry-out and signed overflow with a one-cycle done pulse. Used wherever area matters more than latency, e.g. accumulators and address arithmetic in slow control paths.

---
 rtl/serial_adder.sv | 158 +++++++++++++++
 tb/tb_serial_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. Operands are captured on an accepted start
//   strobe and consumed DIGIT bits per clock through a registered carry.
//   The sum, carry-out and signed overflow appear together with a one-cycle
//   done pulse after WIDTH/DIGIT clocks.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (aborts a running operation)
//   start  in   operation request, sampled only while idle
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in for addition (ignored when sub=1)
//   sub    in   0: a+b+cin, 1: a-b
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse, s/c/ovf just updated
//   s      out  WIDTH-bit result modulo 2^WIDTH
//   c      out  carry out of the MSB (for sub: 1 = no borrow)
//   ovf    out  two's-complement overflow
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_carry;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_s;
   logic              r_c;
   logic              r_ovf;
   logic              r_done;

   logic              w_accept;
   logic              w_last;
   logic [DIGIT:0]    w_sum;
   logic [DIGIT-1:0]  w_psum;
   logic              w_cout;
   logic              w_cin_msb;
   logic [WIDTH-1:0]  w_res_next;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (r_cnt == LAST) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_state == RUN) && (r_cnt == LAST);

   // ------------------------------------------------------------------
   // One DIGIT-wide slice of the addition
   // ------------------------------------------------------------------
   assign w_sum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + (DIGIT+1)'(r_carry);
   assign w_psum = w_sum[DIGIT-1:0];
   assign w_cout = w_sum[DIGIT];
   // On the last step the top bit of this slice is the operand MSB; the
   // carry into it is recovered from its inputs and its sum bit.
   assign w_cin_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_psum[DIGIT-1];

   // Partial sums enter at the MSB end; only the WIDTH-DIGIT bits already
   // produced need storing, the current slice is combined on the fly.
   generate
      if (DIGIT < WIDTH) begin : g_res
         logic [WIDTH-DIGIT-1:0] r_res;

         assign w_res_next = {w_psum, r_res};

         always_ff @(posedge clk) begin
            if (rst) begin
               r_res <= '0;
            end else if (r_state == RUN) begin
               r_res <= w_res_next[WIDTH-1:DIGIT];
            end
         end
      end else begin : g_res_single
         assign w_res_next = w_psum;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Operand shifters, carry, counter and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_c     <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
               r_s    <= w_res_next;
               r_c    <= w_cout;
               r_ovf  <= w_cin_msb ^ w_cout;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign s    = r_s;
   assign c    = r_c;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit DIGIT=1 instance for the
// handshake/abort scenarios, plus 4-bit DIGIT=2 and DIGIT=4 instances swept
// exhaustively against a behavioural model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;

   // 8-bit, DIGIT=1
   logic       st8;
   logic [7:0] a8, b8;
   logic       cin8, sub8;
   logic       busy8, done8, c8, ovf8;
   logic [7:0] s8;

   // 4-bit instances share stimulus
   logic       st4;
   logic [3:0] a4, b4;
   logic       cin4, sub4;
   logic       busy42, done42, c42, ovf42;
   logic [3:0] s42;
   logic       busy44, done44, c44, ovf44;
   logic [3:0] s44;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d8 (
      .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .s(s8), .c(c8), .ovf(ovf8));

   serial_adder #(.WIDTH(4), .DIGIT(2)) u_d42 (
      .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .busy(busy42), .done(done42), .s(s42), .c(c42), .ovf(ovf42));

   serial_adder #(.WIDTH(4), .DIGIT(4)) u_d44 (
      .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .busy(busy44), .done(done44), .s(s44), .c(c44), .ovf(ovf44));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation: start pulsed for one edge, then latency, busy
   // occupancy and results checked against hand-computed values.
   task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic icin, input logic isub,
                      input logic [7:0] es, input logic ec, input logic eovf);
      int lat;
      int bcnt;
      @(negedge clk);
      a8 = ia; b8 = ib; cin8 = icin; sub8 = isub; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      lat = 0; bcnt = 0;
      while (!done8 && lat < 20) begin
         if (busy8) bcnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, 8);
      check({tag, "_busycnt"}, bcnt, 8);
      check({tag, "_busy_at_done"}, busy8, 0);
      check({tag, "_s"}, s8, es);
      check({tag, "_c"}, c8, ec);
      check({tag, "_ovf"}, ovf8, eovf);
      $display("txn %s a=%02h b=%02h cin=%0b sub=%0b -> s=%02h c=%0b ovf=%0b lat=%0d",
               tag, ia, ib, icin, isub, s8, c8, ovf8, lat);
      @(negedge clk);
      check({tag, "_done_pulse"}, done8, 0);
   endtask

   initial begin : stim
      int k;
      int dcnt;
      logic [9:0]  v;
      logic [3:0]  eb;
      logic        ec;
      logic [4:0]  tot;
      logic        eovf;
      int lat, lat2, lat4;
      logic got2, got4;

      rst = 1'b1; st8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
      st4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

      // Reset held two cycles with start asserted
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_s", s8, 0);
      check("rst_c", c8, 0);
      check("rst_ovf", ovf8, 0);
      check("rst_busy42", busy42, 0);
      st8 = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy8, 0);

      // Directed additions and subtractions
      op8("add0f01",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      op8("addff01c",  8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      op8("add7f01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      op8("sub0507",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      op8("sub8001",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Handshake: start held, operands scrambled during RUN, back-to-back
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      k = 0;
      while (!done8 && k < 20) begin
         check("hs_s_hold1", s8, 8'h7F);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         @(negedge clk);
         k++;
      end
      check("hs_lat1", k, 8);
      check("hs_s1", s8, 8'h30);
      check("hs_c1", c8, 0);
      $display("txn hs1 a=10 b=20 -> s=%02h c=%0b lat=%0d", s8, c8, k);
      // Still in the done cycle: these operands are taken at the next edge
      a8 = 8'h40; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
      @(negedge clk);
      k = 1;
      while (!done8 && k < 20) begin
         check("hs_s_hold2", s8, 8'h30);
         a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
         @(negedge clk);
         k++;
      end
      st8 = 1'b0; sub8 = 1'b0;
      check("hs_gap", k, 9);
      check("hs_s2", s8, 8'h41);
      check("hs_ovf2", ovf8, 0);
      $display("txn hs2 a=40 b=01 -> s=%02h gap=%0d", s8, k);
      @(negedge clk);
      check("hs_idle_after", busy8, 0);

      // Abort: reset lands on step 4
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy8, 0);
      check("abort_s", s8, 0);
      check("abort_c", c8, 0);
      check("abort_ovf", ovf8, 0);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) dcnt++;
         @(negedge clk);
      end
      check("abort_no_done", dcnt, 0);
      $display("txn abort a=12 b=34 -> s=%02h busy=%0b", s8, busy8);
      op8("after_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

      // Exhaustive 4-bit sweep, DIGIT=2 and DIGIT=4 in parallel
      for (int i = 0; i < 1024; i++) begin
         v = 10'(i);
         a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sub4 = v[9];
         eb   = sub4 ? ~b4 : b4;
         ec   = sub4 ? 1'b1 : cin4;
         tot  = {1'b0, a4} + {1'b0, eb} + {4'b0, ec};
         eovf = (a4[3] == eb[3]) && (tot[3] != a4[3]);
         st4 = 1'b1;
         @(negedge clk);
         st4 = 1'b0;
         lat = 0; lat2 = 0; lat4 = 0; got2 = 1'b0; got4 = 1'b0;
         while (!(got2 && got4) && lat < 10) begin
            @(negedge clk);
            lat++;
            if (done42 && !got2) begin
               got2 = 1'b1; lat2 = lat;
               check("sw42_s", s42, tot[3:0]);
               check("sw42_c", c42, tot[4]);
               check("sw42_ovf", ovf42, eovf);
            end
            if (done44 && !got4) begin
               got4 = 1'b1; lat4 = lat;
               check("sw44_s", s44, tot[3:0]);
               check("sw44_c", c44, tot[4]);
               check("sw44_ovf", ovf44, eovf);
            end
         end
         check("sw42_lat", lat2, 2);
         check("sw44_lat", lat4, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
